// File: rtl/dmem_arbiter_if.sv
// Bundle of the core port, debug port and memory port around the data-memory arbiter.
// The master side belongs to the requesters and the memory; the slave side belongs to the arbiter.
interface dmem_arbiter_if;

    // Core MEM-stage port
    logic        c_req;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_gnt;
    logic        c_stall;
    logic        c_rvalid;
    logic [31:0] c_rdata;
    logic        c_err;

    // Debug / loader port
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    // Memory port
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_stall, c_rvalid, c_rdata, c_err,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_re, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_stall, c_rvalid, c_rdata, c_err,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_re, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core MEM stage and the debug/loader port.
// Core has priority; a debug requester denied MAX_WAIT cycles in a row is given one forced grant.
module dmem_arbiter #(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WaitMax = WW'(MAX_WAIT);

    typedef enum logic [0:0] {
        CorePri,
        DbgForce
    } state_e;

    state_e          state_q, state_d;
    logic [WW-1:0]   wait_q, wait_d;

    logic            c_gnt, d_gnt;
    logic            c_bad, d_bad;

    logic            c_rvalid_q, c_err_q;
    logic [31:0]     c_rdata_q;
    logic            d_rvalid_q, d_err_q;
    logic [31:0]     d_rdata_q;

    // Misaligned, or any address bit above the word index set, means out of range.
    assign c_bad = (bus.c_addr[1:0] != 2'b00) || (bus.c_addr[31:AW+2] != '0);
    assign d_bad = (bus.d_addr[1:0] != 2'b00) || (bus.d_addr[31:AW+2] != '0);

    // Grant decode from live requests and the registered priority state; nothing granted in reset.
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                CorePri: begin
                    c_gnt = bus.c_req;
                    d_gnt = bus.d_req & ~bus.c_req;
                end
                DbgForce: begin
                    d_gnt = bus.d_req;
                    c_gnt = bus.c_req & ~bus.d_req;
                end
                default: ;
            endcase
        end
    end

    // Starvation counter and priority-state next-state logic.
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        if (bus.d_req && !d_gnt) begin
            wait_d = (wait_q == WaitMax) ? wait_q : wait_q + WW'(1);
        end
        unique case (state_q)
            CorePri:  if (wait_d == WaitMax) state_d = DbgForce;
            DbgForce: if (d_gnt || !bus.d_req) state_d = CorePri;
            default:  state_d = CorePri;
        endcase
    end

    // Priority state and wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CorePri;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Memory port mux; erroneous accesses keep both enables low.
    always_comb begin
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (c_gnt) begin
            bus.mem_re    = ~bus.c_we & ~c_bad;
            bus.mem_we    = bus.c_we & ~c_bad;
            bus.mem_addr  = bus.c_addr;
            bus.mem_wdata = bus.c_wdata;
        end else if (d_gnt) begin
            bus.mem_re    = ~bus.d_we & ~d_bad;
            bus.mem_we    = bus.d_we & ~d_bad;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
        end
    end

    // Per-port response registers; rdata holds until the next response to that port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_rvalid_q <= 1'b0;
            c_err_q    <= 1'b0;
            c_rdata_q  <= '0;
            d_rvalid_q <= 1'b0;
            d_err_q    <= 1'b0;
            d_rdata_q  <= '0;
        end else begin
            c_rvalid_q <= c_gnt;
            c_err_q    <= c_gnt & c_bad;
            if (c_gnt) c_rdata_q <= (c_bad || bus.c_we) ? '0 : bus.mem_rdata;
            d_rvalid_q <= d_gnt;
            d_err_q    <= d_gnt & d_bad;
            if (d_gnt) d_rdata_q <= (d_bad || bus.d_we) ? '0 : bus.mem_rdata;
        end
    end

    assign bus.c_gnt    = c_gnt;
    assign bus.c_stall  = bus.c_req & ~c_gnt;
    assign bus.c_rvalid = c_rvalid_q;
    assign bus.c_err    = c_err_q;
    assign bus.c_rdata  = c_rdata_q;
    assign bus.d_gnt    = d_gnt;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.d_err    = d_err_q;
    assign bus.d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic against a behavioural model.
module tb_dmem_arbiter;

    localparam int unsigned DEPTH    = 1024;
    localparam int unsigned MAX_WAIT = 4;

    logic clk;
    logic rst_n;

    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;

    int vectors    = 0;
    int miscompares = 0;

    dmem_arbiter_if bus ();

    dmem_arbiter #(
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.c_req   = c_req;
    assign bus.c_we    = c_we;
    assign bus.c_addr  = c_addr;
    assign bus.c_wdata = c_wdata;
    assign bus.d_req   = d_req;
    assign bus.d_we    = d_we;
    assign bus.d_addr  = d_addr;
    assign bus.d_wdata = d_wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backdrop contents of a never-written word.
    function automatic logic [31:0] seed(input int unsigned w);
        if (w == 16) return 32'h1234_5678;
        return (w * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    // Environment memory: combinational read, written at the clock edge.
    logic [31:0]      env_mem [0:1023];
    logic [1023:0]    env_vld = '0;
    logic [9:0]       env_idx;
    assign env_idx = bus.mem_addr[11:2];
    assign bus.mem_rdata = !bus.mem_re ? 32'hBAD0_BAD0 :
                           env_vld[env_idx] ? env_mem[env_idx] : seed(32'(env_idx));
    always @(posedge clk) begin
        if (bus.mem_we) begin
            env_mem[env_idx] <= bus.mem_wdata;
            env_vld[env_idx] <= 1'b1;
        end
    end

    // Behavioural model state.
    logic [31:0] ref_mem [0:1023];
    int          m_streak;
    logic        e_c_rvalid, e_c_err, e_d_rvalid, e_d_err;
    logic [31:0] e_c_rdata, e_d_rdata;
    logic        last_cw, last_dw;
    logic        obs_c_gnt, obs_d_gnt, obs_c_stall, obs_mem_re, obs_mem_we;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
    endfunction

    task automatic model_reset();
        m_streak   = 0;
        e_c_rvalid = 1'b0;
        e_c_err    = 1'b0;
        e_c_rdata  = '0;
        e_d_rvalid = 1'b0;
        e_d_err    = 1'b0;
        e_d_rdata  = '0;
    endtask

    // One clock cycle: inputs already applied at posedge+1; checks grant and memory port mid-cycle,
    // advances the model, then checks responses just after the next edge.
    task automatic cycle();
        logic        cw, dw, cb, db, e_re, e_we;
        logic [31:0] e_addr, e_wdata;
        #2;
        dw = d_req && (!c_req || m_streak >= int'(MAX_WAIT));
        cw = c_req && !dw;
        cb = bad(c_addr);
        db = bad(d_addr);
        e_re = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
        if (cw) begin
            e_re = !c_we && !cb; e_we = c_we && !cb; e_addr = c_addr; e_wdata = c_wdata;
        end else if (dw) begin
            e_re = !d_we && !db; e_we = d_we && !db; e_addr = d_addr; e_wdata = d_wdata;
        end
        chk("c_gnt", bus.c_gnt, cw);
        chk("d_gnt", bus.d_gnt, dw);
        chk("c_stall", bus.c_stall, c_req && !cw);
        chk("mem_re", bus.mem_re, e_re);
        chk("mem_we", bus.mem_we, e_we);
        chk("mem_addr", bus.mem_addr, e_addr);
        chk("mem_wdata", bus.mem_wdata, e_wdata);
        obs_c_gnt   = bus.c_gnt;
        obs_d_gnt   = bus.d_gnt;
        obs_c_stall = bus.c_stall;
        obs_mem_re  = bus.mem_re;
        obs_mem_we  = bus.mem_we;
        last_cw = cw;
        last_dw = dw;

        e_c_rvalid = cw; e_c_err = cw && cb;
        e_d_rvalid = dw; e_d_err = dw && db;
        if (cw) e_c_rdata = (cb || c_we) ? 32'h0 : ref_mem[c_addr[11:2]];
        if (dw) e_d_rdata = (db || d_we) ? 32'h0 : ref_mem[d_addr[11:2]];
        if (cw && c_we && !cb) ref_mem[c_addr[11:2]] = c_wdata;
        if (dw && d_we && !db) ref_mem[d_addr[11:2]] = d_wdata;
        if (d_req && !dw) m_streak = (m_streak >= int'(MAX_WAIT)) ? m_streak : m_streak + 1;
        else              m_streak = 0;

        @(posedge clk);
        #1;
        chk("c_rvalid", bus.c_rvalid, e_c_rvalid);
        chk("c_err", bus.c_err, e_c_err);
        chk("c_rdata", bus.c_rdata, e_c_rdata);
        chk("d_rvalid", bus.d_rvalid, e_d_rvalid);
        chk("d_err", bus.d_err, e_d_err);
        chk("d_rdata", bus.d_rdata, e_d_rdata);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(15);
        if (r == 0) return {$urandom_range(31), 2'b00} | 32'($urandom_range(3));
        if (r == 1) return 32'h1000 + {$urandom_range(255), 2'b00};
        return {$urandom_range(31), 2'b00};
    endfunction

    initial begin
        rst_n = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0; c_wdata = 32'h0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h4; d_wdata = 32'h0;
        for (int w = 0; w < 1024; w++) ref_mem[w] = seed(w);
        model_reset();
        last_cw = 1'b0; last_dw = 1'b0;

        // Reset state with both ports requesting.
        #3;
        chk("rst c_gnt", bus.c_gnt, 1'b0);
        chk("rst d_gnt", bus.d_gnt, 1'b0);
        chk("rst mem_re", bus.mem_re, 1'b0);
        chk("rst mem_we", bus.mem_we, 1'b0);
        chk("rst c_rvalid", bus.c_rvalid, 1'b0);
        chk("rst d_rvalid", bus.d_rvalid, 1'b0);
        chk("rst c_err", bus.c_err, 1'b0);
        chk("rst d_err", bus.d_err, 1'b0);
        chk("rst c_rdata", bus.c_rdata, 32'h0);
        chk("rst d_rdata", bus.d_rdata, 32'h0);
        @(posedge clk);
        #1;
        c_req = 1'b0; d_req = 1'b0;
        rst_n = 1'b1;
        cycle();

        // Core store then load at 0x10.
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h10; c_wdata = 32'hDEAD_BEEF;
        cycle();
        chk("st gnt", obs_c_gnt, 1'b1);
        chk("st stall", obs_c_stall, 1'b0);
        chk("st ack", bus.c_rdata, 32'h0);
        c_we = 1'b0;
        cycle();
        chk("ld gnt", obs_c_gnt, 1'b1);
        chk("ld stall", obs_c_stall, 1'b0);
        chk("ld rvalid", bus.c_rvalid, 1'b1);
        chk("ld rdata", bus.c_rdata, 32'hDEAD_BEEF);

        // Debug-only load of 0x40.
        c_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        cycle();
        chk("dbg gnt", obs_d_gnt, 1'b1);
        chk("dbg rvalid", bus.d_rvalid, 1'b1);
        chk("dbg rdata", bus.d_rdata, 32'h1234_5678);
        d_req = 1'b0;
        cycle();

        // Both requesting continuously: 4 core grants, then one forced debug grant.
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h4;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("pat c_gnt", obs_c_gnt, (i % 5) != 4);
            if ((i % 5) == 4) begin
                chk("pat d_gnt", obs_d_gnt, 1'b1);
                chk("pat stall", obs_c_stall, 1'b1);
            end
        end
        c_req = 1'b0; d_req = 1'b0;
        cycle();

        // Misaligned and out-of-range core loads.
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h13;
        cycle();
        chk("mis gnt", obs_c_gnt, 1'b1);
        chk("mis re", obs_mem_re, 1'b0);
        chk("mis we", obs_mem_we, 1'b0);
        chk("mis err", bus.c_err, 1'b1);
        chk("mis rvalid", bus.c_rvalid, 1'b1);
        chk("mis rdata", bus.c_rdata, 32'h0);
        c_addr = 32'h4;
        cycle();
        c_addr = 32'h1000;
        cycle();
        chk("oor gnt", obs_c_gnt, 1'b1);
        chk("oor re", obs_mem_re, 1'b0);
        chk("oor err", bus.c_err, 1'b1);
        chk("oor rdata", bus.c_rdata, 32'h0);

        // Reset clears a visible response asynchronously.
        c_addr = 32'hC;
        cycle();
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst rvalid", bus.c_rvalid, 1'b0);
        chk("arst rdata", bus.c_rdata, 32'h0);
        chk("arst gnt", bus.c_gnt, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        c_req = 1'b0;
        cycle();

        // Reset between a load grant and its response.
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h14;
        #2;
        chk("pre gnt", bus.c_gnt, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("in rst gnt", bus.c_gnt, 1'b0);
        chk("in rst re", bus.mem_re, 1'b0);
        @(posedge clk);
        #1;
        chk("in rst rvalid", bus.c_rvalid, 1'b0);
        c_req = 1'b0;
        rst_n = 1'b1;
        model_reset();
        cycle();
        chk("post rvalid", bus.c_rvalid, 1'b0);
        c_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        cycle();
        chk("post first gnt", obs_c_gnt, 1'b1);

        // Random traffic; an ungranted request is held stable or occasionally withdrawn.
        for (int n = 0; n < 600; n++) begin
            if (!(c_req && !last_cw && $urandom_range(7) != 0)) begin
                c_req   = $urandom_range(3) != 0;
                c_we    = 1'($urandom_range(1));
                c_addr  = rand_addr();
                c_wdata = $urandom();
            end
            if (!(d_req && !last_dw && $urandom_range(7) != 0)) begin
                d_req   = $urandom_range(2) != 0;
                d_we    = 1'($urandom_range(1));
                d_addr  = rand_addr();
                d_wdata = $urandom();
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be DEPTH, default 1024, data-memory depth in 32-bit words, power of two. Address bits used SHALL be [log2(DEPTH)+1:2].
REQ-002 Parameter MAX_WAIT SHALL default to 4: the number of consecutive denied debug cycles before debug is forced to win.
REQ-003 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 c_req, c_we  in  1, 1  core MEM-stage access request and store flag.
REQ-006 c_addr, c_wdata  in  32, 32  core byte address and store data.
REQ-007 c_gnt  out  1  core access is performed this cycle.
REQ-008 c_stall  out  1  equals c_req AND NOT c_gnt; drives the pipeline hold.
REQ-009 c_rvalid, c_rdata, c_err  out  1, 32, 1  core load response, one cycle after grant.
REQ-010 d_req, d_we, d_addr, d_wdata  in  1, 1, 32, 32  debug/loader port request.
REQ-011 d_gnt, d_rvalid, d_rdata, d_err  out  1, 1, 32, 1  debug grant and response.
REQ-012 mem_re, mem_we  out  1, 1  memory read and write enables.
REQ-013 mem_addr, mem_wdata  out  32, 32  memory address and write data.
REQ-014 mem_rdata  in  32  memory read data, combinational from mem_addr when mem_re is high.

Function
REQ-015 At most one of c_gnt and d_gnt SHALL be high in any cycle. Grants SHALL be combinational from the requests and the registered state.
REQ-016 FSM states SHALL be CORE_PRI and DBG_FORCE.
- In CORE_PRI, core wins whenever c_req is high; debug wins only when c_req is low.
- In DBG_FORCE, debug wins whenever d_req is high.
REQ-017 A wait counter (width clog2(MAX_WAIT+1)) SHALL increment in each cycle with d_req=1 and d_gnt=0. It SHALL clear on d_gnt or d_req=0 and saturate at MAX_WAIT.
REQ-018 CORE_PRI SHALL go to DBG_FORCE at the edge where the counter reaches MAX_WAIT.
REQ-019 DBG_FORCE SHALL return to CORE_PRI after exactly one debug grant, or immediately if d_req drops.
REQ-020 In a grant cycle the memory port SHALL be driven from the granted requester:
- mem_addr and mem_wdata from that requester.
- mem_we equals its we flag; mem_re equals NOT we.
- With no grant, mem_re, mem_we, mem_addr and mem_wdata SHALL be 0.
REQ-021 An access SHALL be erroneous if addr[1:0] is not 0 or addr is at or above 4*DEPTH. An erroneous access SHALL:
- still be granted;
- drive mem_re=mem_we=0;
- pulse x_err with x_rvalid one cycle later;
- return x_rdata=0.
REQ-022 For a granted valid load, mem_rdata SHALL be registered into x_rdata. x_rvalid SHALL be high for exactly the next cycle.
REQ-023 A granted valid store SHALL assert x_rvalid one cycle later with x_rdata=0 (write acknowledge).
REQ-024 x_rdata SHALL hold its value until the next response to that port.
REQ-025 A requester SHALL hold req, we, addr and wdata stable until granted. Dropping req before grant SHALL cancel the request with no memory effect.
REQ-026 Back-to-back grants to the same port SHALL be allowed every cycle. Throughput SHALL be one access per cycle.

Reset
REQ-027 When rst_n is low, the following SHALL be forced immediately, independent of clk:
- state=CORE_PRI and wait counter=0;
- c_rvalid, d_rvalid, c_err and d_err = 0;
- c_rdata and d_rdata = 0.
REQ-028 While rst_n is low, c_gnt, d_gnt, mem_re and mem_we SHALL be 0.
REQ-029 A response pending when reset is asserted SHALL be discarded and SHALL NOT appear after reset is released.

Verification
REQ-030 Core only: store 0xDEADBEEF to 0x10, then load 0x10. Required: c_gnt is high both cycles and c_stall stays 0. The load returns c_rvalid with c_rdata=0xDEADBEEF one cycle after its grant.
REQ-031 Debug only: load 0x40 with memory holding 0x12345678. Required: d_gnt in the same cycle, then d_rvalid=1 and d_rdata=0x12345678 one cycle later.
REQ-032 Both requesting continuously with MAX_WAIT=4. Required: core is granted 4 cycles, then debug 1 cycle, with c_stall=1 in that debug cycle; the pattern repeats.
REQ-033 Core load from 0x13, and separately from 0x1000 with DEPTH=1024. Required: c_gnt=1 with mem_re=mem_we=0, then c_err=1, c_rvalid=1 and c_rdata=0.
REQ-034 Assert rst_n low in the cycle between a load grant and its response. Required: no rvalid after reset is released, and the first post-reset grant goes to core.
